// File: rtl/slv_pkg.sv
// Shared types and widths for the slave reset controller.
// SLV_RST_CTRL_TIMEOUT_EN adds the ERROR state to the sequencing enum.
package slv_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int RST_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RECOVER = 3'd5
`ifdef SLV_RST_CTRL_TIMEOUT_EN
    ,
    ST_ERROR   = 3'd6
`endif
  } state_e;

  function automatic logic [RST_CNT_WIDTH-1:0] sat_inc(input logic [RST_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + RST_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/slv_rst_cnt.sv
// Clearable saturating up-counter with a terminal-value compare, shared by
// the drain, hold and handshake-timeout phases.
module slv_rst_cnt #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] term_val_i,
  output logic             term_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !(&cnt_q)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/slv_rst_ctrl.sv
// Slave reset sequencer: isolate, drain, reset handshake, hold, release, recover.
// Define SLV_RST_CTRL_TIMEOUT_EN to add handshake timeouts and the ERROR state.
module slv_rst_ctrl
  import slv_pkg::*;
#(
  parameter int CntWidth      = CNT_WIDTH_DEF,
  parameter int DrainCycles   = 256,
  parameter int HoldCycles    = 8,
  parameter int TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     guard_ena_i,
  input  logic                     trigger_i,
  input  logic                     sw_trigger_i,
  input  logic                     idle_i,
  output logic                     isolate_o,
  output logic                     guard_ena_o,
  output logic                     slv_rst_req_o,
  input  logic                     slv_rst_stat_i,
  output logic                     busy_o,
  output logic [RST_CNT_WIDTH-1:0] rst_cnt_o,
  output logic                     err_o,
  input  logic                     err_clr_i
);

  if (DrainCycles < 1 || DrainCycles >= (1 << CntWidth)) begin : g_bad_drain
    $error("DrainCycles must be in 1 .. 2**CntWidth-1");
  end
  if (HoldCycles < 1 || HoldCycles >= (1 << CntWidth)) begin : g_bad_hold
    $error("HoldCycles must be in 1 .. 2**CntWidth-1");
  end
  if (TimeoutCycles < 1 || TimeoutCycles >= (1 << CntWidth)) begin : g_bad_timeout
    $error("TimeoutCycles must be in 1 .. 2**CntWidth-1");
  end

  state_e              state_q, state_d;
  logic                cnt_clr;
  logic                cnt_term;
  logic [CntWidth-1:0] term_val;

  // Handshake valid/ready semantics do not apply here: every input is a level
  // sampled on the clock edge, and a trigger is only honoured while in IDLE.
  always_comb begin
    state_d  = state_q;
    term_val = CntWidth'(TimeoutCycles - 1);
    case (state_q)
      ST_IDLE: begin
        if (trigger_i || sw_trigger_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        term_val = CntWidth'(DrainCycles - 1);
        if (idle_i || cnt_term) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (slv_rst_stat_i) state_d = ST_HOLD;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
        else if (cnt_term) state_d = ST_ERROR;
`endif
      end
      ST_HOLD: begin
        term_val = CntWidth'(HoldCycles - 1);
        if (cnt_term) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!slv_rst_stat_i) state_d = ST_RECOVER;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
        else if (cnt_term) state_d = ST_ERROR;
`endif
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
`ifdef SLV_RST_CTRL_TIMEOUT_EN
      ST_ERROR: begin
        if (err_clr_i) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every phase change restarts the shared counter so each phase measures its own dwell.
  assign cnt_clr = (state_d != state_q);

  slv_rst_cnt #(
    .Width (CntWidth)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (cnt_clr),
    .en_i       (1'b1),
    .term_val_i (term_val),
    .term_o     (cnt_term)
  );

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      busy_o        <= 1'b0;
      isolate_o     <= 1'b0;
      slv_rst_req_o <= 1'b0;
      guard_ena_o   <= 1'b0;
      rst_cnt_o     <= '0;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
      err_o         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      busy_o        <= (state_d != ST_IDLE);
      isolate_o     <= !(state_d inside {ST_IDLE, ST_RECOVER});
      slv_rst_req_o <= (state_d inside {ST_ASSERT, ST_HOLD});
      guard_ena_o   <= (state_d inside {ST_IDLE, ST_RECOVER}) && guard_ena_i;
      if (state_d == ST_RECOVER) rst_cnt_o <= sat_inc(rst_cnt_o);
`ifdef SLV_RST_CTRL_TIMEOUT_EN
      err_o         <= (state_d == ST_ERROR);
`endif
    end
  end

`ifndef SLV_RST_CTRL_TIMEOUT_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_slv_rst_ctrl.sv
// Bench for slv_rst_ctrl: phase-dwell reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_slv_rst_ctrl;

  localparam int DRAIN   = 256;
  localparam int HOLD    = 8;
  localparam int TIMEOUT = 1024;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic       guard_ena_i = 1'b0, trigger_i = 1'b0, sw_trigger_i = 1'b0, idle_i = 1'b1;
  logic       slv_rst_stat_i = 1'b0, err_clr_i = 1'b0;
  logic       isolate_o, guard_ena_o, slv_rst_req_o, busy_o, err_o;
  logic [7:0] rst_cnt_o;

  int errors = 0;
  int checks = 0;

  slv_rst_ctrl #(
    .CntWidth      (16),
    .DrainCycles   (DRAIN),
    .HoldCycles    (HOLD),
    .TimeoutCycles (TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .guard_ena_i    (guard_ena_i),
    .trigger_i      (trigger_i),
    .sw_trigger_i   (sw_trigger_i),
    .idle_i         (idle_i),
    .isolate_o      (isolate_o),
    .guard_ena_o    (guard_ena_o),
    .slv_rst_req_o  (slv_rst_req_o),
    .slv_rst_stat_i (slv_rst_stat_i),
    .busy_o         (busy_o),
    .rst_cnt_o      (rst_cnt_o),
    .err_o          (err_o),
    .err_clr_i      (err_clr_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave reset domain responder ----------------
  logic slave_auto = 1'b1;
  int   ack_dly = 2, rel_dly = 1, ack_cnt = 0, rel_cnt = 0;

  always @(negedge clk) begin
    if (!slave_auto) begin
      slv_rst_stat_i = 1'b0;
    end else if (slv_rst_req_o && !slv_rst_stat_i) begin
      if (ack_cnt >= ack_dly) slv_rst_stat_i = 1'b1;
      else ack_cnt++;
    end else if (!slv_rst_req_o && slv_rst_stat_i) begin
      if (rel_cnt >= rel_dly) slv_rst_stat_i = 1'b0;
      else rel_cnt++;
    end else begin
      ack_cnt = 0;
      rel_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  // Phase plus dwell time (cycles spent in the phase so far); outputs follow the phase.
  localparam int P_IDLE = 0, P_DRAIN = 1, P_ASSERT = 2, P_HOLD = 3;
  localparam int P_RELEASE = 4, P_RECOVER = 5, P_ERROR = 6;

  int   ph = P_IDLE, m_nxt = P_IDLE, dwell = 0, m_cnt = 0;
  logic m_gsmp = 1'b0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] model_vec();
    logic b, i, r, g, e;
    b = (ph != P_IDLE);
    i = (ph != P_IDLE) && (ph != P_RECOVER);
    r = (ph == P_ASSERT) || (ph == P_HOLD);
    g = ((ph == P_IDLE) || (ph == P_RECOVER)) ? m_gsmp : 1'b0;
    e = (ph == P_ERROR);
    return {b, i, r, g, e, 8'(m_cnt)};
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ph = P_IDLE; dwell = 0; m_cnt = 0; m_gsmp = 1'b0;
      exp_q.delete();
      exp_q.push_back(model_vec());
    end else begin
      dwell++;
      m_nxt = ph;
      case (ph)
        P_IDLE:    if (trigger_i || sw_trigger_i) m_nxt = P_DRAIN;
        P_DRAIN:   if (idle_i || dwell >= DRAIN) m_nxt = P_ASSERT;
        P_ASSERT:  if (slv_rst_stat_i) m_nxt = P_HOLD;
                   else if (TO_EN && dwell >= TIMEOUT) m_nxt = P_ERROR;
        P_HOLD:    if (dwell >= HOLD) m_nxt = P_RELEASE;
        P_RELEASE: if (!slv_rst_stat_i) m_nxt = P_RECOVER;
                   else if (TO_EN && dwell >= TIMEOUT) m_nxt = P_ERROR;
        P_RECOVER: m_nxt = P_IDLE;
        default:   if (err_clr_i) m_nxt = P_IDLE;
      endcase
      if (m_nxt == P_RECOVER && m_cnt < 255) m_cnt++;
      if (m_nxt != ph) dwell = 0;
      ph = m_nxt;
      m_gsmp = guard_ena_i;
      exp_q.push_back(model_vec());
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(posedge clk) begin
    logic [12:0] e;
    #2;
    if (exp_q.size() == 0) begin
      check("exp_q underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("busy_o",        busy_o,        e[12]);
      check("isolate_o",     isolate_o,     e[11]);
      check("slv_rst_req_o", slv_rst_req_o, e[10]);
      check("guard_ena_o",   guard_ena_o,   e[9]);
      check("err_o",         err_o,         e[8]);
      check("rst_cnt_o",     rst_cnt_o,     e[7:0]);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return busy_o;
      1:       return slv_rst_req_o;
      2:       return slv_rst_stat_i;
      default: return err_o;
    endcase
  endfunction

  task automatic wait_sig(input string what, input int sel, input logic val,
                          input int bound, output int n);
    n = 0;
    while (sig(sel) !== val && n < bound) begin
      @(posedge clk); #2;
      n++;
    end
    check({"wait ", what}, sig(sel), val);
  endtask

  task automatic pulse(input logic hw, input logic sw);
    @(negedge clk);
    trigger_i = hw; sw_trigger_i = sw;
    @(negedge clk);
    trigger_i = 1'b0; sw_trigger_i = 1'b0;
  endtask

  task automatic cycles(input int k);
    repeat (k) begin @(posedge clk); #2; end
  endtask

  // ---------------- stimulus ----------------
  int n, hi, idle_pct;

  initial begin
    cycles(2);
    check("reset busy_o", busy_o, 0);
    check("reset rst_cnt_o", rst_cnt_o, 0);
    check("reset slv_rst_req_o", slv_rst_req_o, 0);
    @(negedge clk); rst_ni = 1'b1;
    guard_ena_i = 1'b1;

    // Single hardware trigger, slave acks on the third ASSERT cycle.
    ack_dly = 2; rel_dly = 1;
    pulse(1'b1, 1'b0);
    wait_sig("req rise", 1, 1'b1, 20, n);
    hi = 0;
    while (slv_rst_req_o === 1'b1 && hi < 50) begin
      if (hi == 5) check("guard_ena_o mid-sequence", guard_ena_o, 0);
      cycles(1);
      hi++;
    end
    check("req high cycles", hi, 3 + HOLD);
    wait_sig("busy fall", 0, 1'b0, 30, n);
    check("cycles release to idle", n, 3);
    check("rst_cnt_o after 1st", rst_cnt_o, 1);

    // Drain limit with idle_i stuck low.
    idle_i = 1'b0;
    pulse(1'b0, 1'b1);
    wait_sig("busy rise drain", 0, 1'b1, 10, n);
    wait_sig("assert after drain", 1, 1'b1, 400, n);
    check("drain cycles", n, DRAIN);
    idle_i = 1'b1;
    wait_sig("busy fall drain", 0, 1'b0, 100, n);
    check("rst_cnt_o after 2nd", rst_cnt_o, 2);

    // Software trigger during HOLD is dropped.
    pulse(1'b1, 1'b0);
    wait_sig("req rise hold", 1, 1'b1, 20, n);
    wait_sig("ack", 2, 1'b1, 20, n);
    cycles(2);
    pulse(1'b0, 1'b1);
    wait_sig("busy fall hold", 0, 1'b0, 60, n);
    cycles(20);
    check("no queued seq", busy_o, 0);
    check("rst_cnt_o after 3rd", rst_cnt_o, 3);

    // Both triggers together start one sequence.
    pulse(1'b1, 1'b1);
    wait_sig("busy rise both", 0, 1'b1, 10, n);
    wait_sig("busy fall both", 0, 1'b0, 60, n);
    cycles(10);
    check("single seq busy", busy_o, 0);
    check("rst_cnt_o after 4th", rst_cnt_o, 4);
    check("guard_ena_o idle", guard_ena_o, 1);

    // Reset in the middle of HOLD.
    pulse(1'b1, 1'b0);
    wait_sig("req rise rst", 1, 1'b1, 20, n);
    wait_sig("ack rst", 2, 1'b1, 20, n);
    cycles(3);
    @(negedge clk); rst_ni = 1'b0; #1;
    check("rst slv_rst_req_o", slv_rst_req_o, 0);
    check("rst isolate_o", isolate_o, 0);
    check("rst busy_o", busy_o, 0);
    check("rst guard_ena_o", guard_ena_o, 0);
    check("rst rst_cnt_o", rst_cnt_o, 0);
    check("rst err_o", err_o, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    cycles(2);
    check("post-rst busy_o", busy_o, 0);

`ifdef SLV_RST_CTRL_TIMEOUT_EN
    // Slave never acknowledges: ERROR after TIMEOUT ASSERT cycles.
    slave_auto = 1'b0;
    pulse(1'b1, 1'b0);
    wait_sig("req rise to", 1, 1'b1, 20, n);
    wait_sig("err rise", 3, 1'b1, TIMEOUT + 50, n);
    check("timeout cycles", n, TIMEOUT);
    check("err req low", slv_rst_req_o, 0);
    check("err isolate", isolate_o, 1);
    @(negedge clk); err_clr_i = 1'b1;
    @(negedge clk); err_clr_i = 1'b0;
    check("err cleared", err_o, 0);
    check("err busy", busy_o, 0);
    slave_auto = 1'b1;
`endif

    // Randomized traffic including occasional resets.
    idle_pct = 80;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i % 300 == 0) begin
        case ($urandom_range(0, 3))
          0:       idle_pct = 0;
          1:       idle_pct = 5;
          2:       idle_pct = 50;
          default: idle_pct = 95;
        endcase
      end
      trigger_i    = ($urandom_range(0, 39) == 0);
      sw_trigger_i = ($urandom_range(0, 49) == 0);
      idle_i       = ($urandom_range(0, 99) < idle_pct);
      err_clr_i    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) guard_ena_i = ~guard_ena_i;
      if (!busy_o) begin
        ack_dly = $urandom_range(0, 5);
        rel_dly = $urandom_range(0, 5);
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
      end
    end
    @(negedge clk);
    trigger_i = 1'b0; sw_trigger_i = 1'b0; idle_i = 1'b1; err_clr_i = 1'b0;
    wait_sig("final idle", 0, 1'b0, 400, n);
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
